// File: rtl/barrel_pkg.sv
// ============================================================================
//  Module      : barrel_pkg
//  Description : Op-code enum and stage-placement helpers for barrel_shifter_pipe.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package barrel_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 3'b000,
        OP_ROR = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    function automatic int levels_per_stage(input int shamt_w, input int pipe_stages);
        return (shamt_w + pipe_stages - 1) / pipe_stages;
    endfunction

    // Stages are counted from level 0 upwards so the final register always follows level 0.
    function automatic int stage_of_level(input int level, input int shamt_w, input int pipe_stages);
        return pipe_stages - 1 - level / levels_per_stage(shamt_w, pipe_stages);
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_level.sv
// ============================================================================
//  Module      : barrel_level
//  Description : One combinational mux level shifting/rotating by SHIFT bits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_level
    import barrel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic             en_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_ROL:  data_o = {data_i[WIDTH-SHIFT-1:0], data_i[WIDTH-1:WIDTH-SHIFT]};
                OP_ROR:  data_o = {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]};
                OP_SLL:  data_o = {data_i[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
                OP_SRL:  data_o = {{SHIFT{1'b0}}, data_i[WIDTH-1:SHIFT]};
                OP_SRA:  data_o = {{SHIFT{sign_i}}, data_i[WIDTH-1:SHIFT]};
                default: data_o = data_i;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
//  Module      : barrel_shifter_pipe
//  Description : Pipelined rotate/shift unit with valid/ready on both sides.
//                Define BARREL_SHIFTER_FLAGS_EN to add out_zero_o/out_carry_o.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter int  WIDTH       = 32,
    parameter int  PIPE_STAGES = 1,
    localparam int SHAMT_W     = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   in_data_i,
    input  logic [SHAMT_W-1:0] in_shamt_i,
    input  logic [OP_W-1:0]    in_op_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_data_o
`ifdef BARREL_SHIFTER_FLAGS_EN
    ,
    output logic               out_zero_o,
    output logic               out_carry_o
`endif
);

    localparam int LPS = levels_per_stage(SHAMT_W, PIPE_STAGES);

    logic [PIPE_STAGES-1:0] valid_q, valid_d, sign_q, sign_d;
    logic [WIDTH-1:0]       data_q  [PIPE_STAGES];
    logic [WIDTH-1:0]       data_d  [PIPE_STAGES];
    logic [OP_W-1:0]        op_q    [PIPE_STAGES];
    logic [OP_W-1:0]        op_d    [PIPE_STAGES];
    logic [SHAMT_W-1:0]     shamt_q [PIPE_STAGES];
    logic [SHAMT_W-1:0]     shamt_d [PIPE_STAGES];

    logic [WIDTH-1:0]       w_stage_in    [PIPE_STAGES];
    logic [WIDTH-1:0]       w_stage_out   [PIPE_STAGES];
    logic [OP_W-1:0]        w_stage_op    [PIPE_STAGES];
    logic [SHAMT_W-1:0]     w_stage_shamt [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] w_stage_sign, w_stage_src_valid, w_accept;
    logic                   w_unused;

`ifdef BARREL_SHIFTER_FLAGS_EN
    logic [PIPE_STAGES-1:0] zero_q, zero_d, carry_q, carry_d;
    logic [WIDTH-1:0]       w_sll0, w_srl0;
    logic [SHAMT_W-1:0]     w_idx_up, w_idx_dn;
    logic                   w_zero0, w_carry0;

    // Flags come from the original operand: WIDTH-n and n-1 are the last bits to leave.
    always_comb begin
        w_sll0   = in_data_i << in_shamt_i;
        w_srl0   = in_data_i >> in_shamt_i;
        w_idx_up = '0 - in_shamt_i;
        w_idx_dn = in_shamt_i - SHAMT_W'(1);
        w_zero0  = (in_data_i == '0);
        w_carry0 = 1'b0;
        case (in_op_i)
            OP_ROL:  w_carry0 = in_data_i[w_idx_up];
            OP_ROR:  w_carry0 = in_data_i[w_idx_dn];
            OP_SLL: begin
                w_zero0  = (w_sll0 == '0);
                w_carry0 = in_data_i[w_idx_up];
            end
            OP_SRL: begin
                w_zero0  = (w_srl0 == '0);
                w_carry0 = in_data_i[w_idx_dn];
            end
            OP_SRA: begin
                w_zero0  = (w_srl0 == '0) && !in_data_i[WIDTH-1];
                w_carry0 = in_data_i[w_idx_dn];
            end
            default: w_carry0 = 1'b0;
        endcase
        if (in_shamt_i == '0) begin
            w_carry0 = 1'b0;
        end
    end

    assign out_zero_o  = zero_q[PIPE_STAGES-1];
    assign out_carry_o = carry_q[PIPE_STAGES-1];
`endif

    always_comb begin
        w_stage_in[0]        = in_data_i;
        w_stage_op[0]        = in_op_i;
        w_stage_shamt[0]     = in_shamt_i;
        w_stage_sign[0]      = in_data_i[WIDTH-1];
        w_stage_src_valid[0] = in_valid_i;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            w_stage_in[s]        = data_q[s-1];
            w_stage_op[s]        = op_q[s-1];
            w_stage_shamt[s]     = shamt_q[s-1];
            w_stage_sign[s]      = sign_q[s-1];
            w_stage_src_valid[s] = valid_q[s-1];
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
        localparam int STAGE = stage_of_level(k, SHAMT_W, PIPE_STAGES);
        logic [WIDTH-1:0] w_in, w_out;
        if (k == SHAMT_W - 1) begin : g_head
            assign w_in = w_stage_in[STAGE];
        end else if (stage_of_level(k + 1, SHAMT_W, PIPE_STAGES) != STAGE) begin : g_head
            assign w_in = w_stage_in[STAGE];
        end else begin : g_chain
            assign w_in = g_lvl[k+1].w_out;
        end
        barrel_level #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_level (
            .data_i (w_in),
            .op_i   (w_stage_op[STAGE]),
            .en_i   (w_stage_shamt[STAGE][k]),
            .sign_i (w_stage_sign[STAGE]),
            .data_o (w_out)
        );
    end

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int LOWEST = (PIPE_STAGES - 1 - s) * LPS;
        if (LOWEST < SHAMT_W) begin : g_levels
            assign w_stage_out[s] = g_lvl[LOWEST].w_out;
        end else begin : g_passthru
            assign w_stage_out[s] = w_stage_in[s];
        end
    end

    // Ready ripples back from the consumer; a stage may load if empty or if it drains now.
    always_comb begin
        logic acc;
        acc = out_ready_i;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            acc         = !valid_q[s] || acc;
            w_accept[s] = acc;
        end
    end

    always_comb begin
        valid_d = valid_q;
        sign_d  = sign_q;
        data_d  = data_q;
        op_d    = op_q;
        shamt_d = shamt_q;
`ifdef BARREL_SHIFTER_FLAGS_EN
        zero_d  = zero_q;
        carry_d = carry_q;
`endif
        for (int s = 0; s < PIPE_STAGES; s++) begin
            if (w_accept[s]) begin
                valid_d[s] = w_stage_src_valid[s];
                if (w_stage_src_valid[s]) begin
                    data_d[s]  = w_stage_out[s];
                    op_d[s]    = w_stage_op[s];
                    shamt_d[s] = w_stage_shamt[s];
                    sign_d[s]  = w_stage_sign[s];
`ifdef BARREL_SHIFTER_FLAGS_EN
                    zero_d[s]  = (s == 0) ? w_zero0  : zero_q[s-1];
                    carry_d[s] = (s == 0) ? w_carry0 : carry_q[s-1];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            sign_q  <= '0;
`ifdef BARREL_SHIFTER_FLAGS_EN
            zero_q  <= '0;
            carry_q <= '0;
`endif
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_q[s]  <= '0;
                op_q[s]    <= '0;
                shamt_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
`ifdef BARREL_SHIFTER_FLAGS_EN
            zero_q  <= zero_d;
            carry_q <= carry_d;
`endif
        end
    end

    // Control copies past their last consuming level are intentionally dangling.
    always_comb begin
        w_unused = 1'b0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_unused = w_unused ^ (^op_q[s]) ^ (^shamt_q[s]) ^ sign_q[s] ^ (^w_stage_shamt[s]);
        end
    end

    assign in_ready_o  = w_accept[0];
    assign out_valid_o = valid_q[PIPE_STAGES-1];
    assign out_data_o  = data_q[PIPE_STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
// ============================================================================
//  Module      : tb_barrel_shifter_pipe
//  Description : Scoreboard bench for barrel_shifter_pipe at PIPE_STAGES 1/3/5;
//                flag outputs are checked when BARREL_SHIFTER_FLAGS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_barrel_shifter_pipe;
    import barrel_pkg::*;

    localparam int W  = 32;
    localparam int ND = 3;

    function automatic int ps_of(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
        logic         carry;
        logic [31:0]  edge_no;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [W-1:0] in_data   [ND];
    logic [4:0]   in_shamt  [ND];
    logic [2:0]   in_op     [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [W-1:0] out_data  [ND];
`ifdef BARREL_SHIFTER_FLAGS_EN
    logic         out_zero  [ND];
    logic         out_carry [ND];
`endif

    exp_t         sb [ND][$];
    bit           exact_lat [ND];
    logic [31:0]  cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        barrel_shifter_pipe #(
            .WIDTH       (W),
            .PIPE_STAGES (ps_of(g))
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .in_data_i   (in_data[g]),
            .in_shamt_i  (in_shamt[g]),
            .in_op_i     (in_op[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .out_data_o  (out_data[g])
`ifdef BARREL_SHIFTER_FLAGS_EN
            ,
            .out_zero_o  (out_zero[g]),
            .out_carry_o (out_carry[g])
`endif
        );
    end

    function automatic exp_t model(input logic [W-1:0] d, input logic [4:0] n, input logic [2:0] op);
        exp_t         e;
        logic [W-1:0] r;
        int           ni;
        ni      = int'(n);
        r       = d;
        e.carry = 1'b0;
        case (op)
            3'b000:  for (int i = 0; i < W; i++) r[i] = d[(i - ni + W) % W];
            3'b001:  for (int i = 0; i < W; i++) r[i] = d[(i + ni) % W];
            3'b010:  r = d << ni;
            3'b011:  r = d >> ni;
            3'b100:  r = $signed(d) >>> ni;
            default: r = d;
        endcase
        if (ni != 0) begin
            case (op)
                3'b000:         e.carry = r[0];
                3'b001:         e.carry = r[W-1];
                3'b010:         e.carry = d[W-ni];
                3'b011, 3'b100: e.carry = d[ni-1];
                default:        e.carry = 1'b0;
            endcase
        end
        e.data    = r;
        e.zero    = (r == '0);
        e.edge_no = '0;
        return e;
    endfunction

    // Output side of the scoreboard: a transfer at the coming edge is visible here.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < ND; g++) begin
            if (rst_n && out_valid[g] && out_ready[g]) begin
                n_checks++;
                if (sb[g].size() == 0) begin
                    $display("FAIL unexpected_beat dut%0d: got %h, required no output", g, out_data[g]);
                end else begin
                    e = sb[g].pop_front();
                    if (out_data[g] !== e.data)
                        $display("FAIL out_data dut%0d: got %h, required %h", g, out_data[g], e.data);
                    else
                        n_pass++;
`ifdef BARREL_SHIFTER_FLAGS_EN
                    n_checks++;
                    if (out_zero[g] !== e.zero || out_carry[g] !== e.carry)
                        $display("FAIL flags dut%0d: got z=%b c=%b, required z=%b c=%b",
                                 g, out_zero[g], out_carry[g], e.zero, e.carry);
                    else
                        n_pass++;
`endif
                    if (exact_lat[g]) begin
                        n_checks++;
                        if (cyc !== e.edge_no + 32'(ps_of(g)) - 32'd1)
                            $display("FAIL latency dut%0d: out at edge %0d, required %0d",
                                     g, cyc, e.edge_no + 32'(ps_of(g)) - 32'd1);
                        else
                            n_pass++;
                    end
                end
            end
        end
    end

    // Presents one beat; the expectation is queued once the DUT accepts it.
    task automatic send(input int g, input logic [W-1:0] d, input logic [4:0] n, input logic [2:0] op);
        exp_t e;
        int   waited;
        in_valid[g] = 1'b1;
        in_data[g]  = d;
        in_shamt[g] = n;
        in_op[g]    = op;
        waited      = 0;
        @(negedge clk);
        while (!in_ready[g] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[g]) begin
            n_checks++;
            $display("FAIL send_timeout dut%0d: in_ready got 0, required 1", g);
        end else begin
            e         = model(d, n, op);
            e.edge_no = cyc + 32'd1;
            sb[g].push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int g, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sb[g].size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++) begin
            n_checks++;
            if (out_valid[g] !== 1'b0) $display("FAIL reset_valid dut%0d: got %b, required 0", g, out_valid[g]);
            else n_pass++;
            n_checks++;
            if (out_data[g] !== '0) $display("FAIL reset_data dut%0d: got %h, required 0", g, out_data[g]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++) begin
            n_checks++;
            if (in_ready[g] !== 1'b1) $display("FAIL reset_ready dut%0d: got %b, required 1", g, in_ready[g]);
            else n_pass++;
        end
    endtask

    task automatic test_rotate();
        bit ok;
        send(0, 32'hF0F0_F0F0, 5'd4, OP_ROL);
        send(0, 32'h8000_0001, 5'd1, OP_ROR);
        in_valid[0] = 1'b0;
        wait_empty(0, ok);
        n_checks++;
        if (!ok) $display("FAIL rotate_drain: pending %0d, required 0", sb[0].size());
        else n_pass++;
    endtask

    task automatic test_shifts();
        bit ok;
        send(0, 32'h0000_0003, 5'd31, OP_SLL);
        send(0, 32'h8000_0000, 5'd4,  OP_SRL);
        send(0, 32'h8000_0000, 5'd4,  OP_SRA);
        send(0, 32'h8000_0000, 5'd31, OP_SRA);
        in_valid[0] = 1'b0;
        wait_empty(0, ok);
        n_checks++;
        if (!ok) $display("FAIL shift_drain: pending %0d, required 0", sb[0].size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < 8; i++)
            send(2, 32'h0123_4567 * (i + 1), 5'(3 * i + 1), 3'(i % 5));
        in_valid[2] = 1'b0;
        wait_empty(2, ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_drain: pending %0d, required 0", sb[2].size());
        else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        out_ready[1] = 1'b0;
        exact_lat[1] = 1'b0;
        send(1, 32'h1111_0001, 5'd3,  OP_ROL);
        send(1, 32'h8000_00F0, 5'd7,  OP_SRA);
        send(1, 32'hDEAD_BEEF, 5'd12, OP_ROR);
        in_valid[1] = 1'b1;
        in_data[1]  = 32'h0000_FFFF;
        in_shamt[1] = 5'd8;
        in_op[1]    = OP_SLL;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready[1] !== 1'b0) $display("FAIL stall_ready cycle%0d: got %b, required 0", i, in_ready[1]);
            else n_pass++;
            n_checks++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== sb[1][0].data)
                $display("FAIL stall_hold cycle%0d: got v=%b %h, required v=1 %h",
                         i, out_valid[1], out_data[1], sb[1][0].data);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
        send(1, 32'h0000_FFFF, 5'd8, OP_SLL);
        in_valid[1] = 1'b0;
        wait_empty(1, ok);
        n_checks++;
        if (!ok) $display("FAIL stall_drain: pending %0d, required 0", sb[1].size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        bit ok;
        send(2, 32'hCAFE_0001, 5'd2, OP_ROL);
        send(2, 32'hCAFE_0002, 5'd5, OP_SRL);
        send(2, 32'hCAFE_0003, 5'd9, OP_SLL);
        in_valid[2] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid[2] !== 1'b0) $display("FAIL midreset_valid: got %b, required 0", out_valid[2]);
        else n_pass++;
        n_checks++;
        if (out_data[2] !== '0) $display("FAIL midreset_data: got %h, required 0", out_data[2]);
        else n_pass++;
        for (int g = 0; g < ND; g++) sb[g].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready[2] !== 1'b1) $display("FAIL midreset_ready: got %b, required 1", in_ready[2]);
        else n_pass++;
        send(2, 32'h1234_5678, 5'd5, 3'b111);
        in_valid[2] = 1'b0;
        wait_empty(2, ok);
        n_checks++;
        if (!ok) $display("FAIL midreset_drain: pending %0d, required 0", sb[2].size());
        else n_pass++;
    endtask

    task automatic test_shamt_zero();
        bit ok;
        for (int op = 0; op < 5; op++)
            send(0, 32'hA5A5_A5A5, 5'd0, 3'(op));
        in_valid[0] = 1'b0;
        wait_empty(0, ok);
        n_checks++;
        if (!ok) $display("FAIL zero_shift_drain: pending %0d, required 0", sb[0].size());
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        bit done;
        for (int g = 0; g < ND; g++) begin
            exact_lat[g] = 1'b0;
            done         = 1'b0;
            fork
                begin
                    for (int i = 0; i < 30; i++)
                        send(g, $urandom, 5'($urandom), 3'($urandom));
                    in_valid[g] = 1'b0;
                    done        = 1'b1;
                end
                begin
                    while (!done) begin
                        out_ready[g] = ($urandom_range(0, 3) != 0);
                        @(posedge clk);
                        #1;
                    end
                    out_ready[g] = 1'b1;
                end
            join
            wait_empty(g, ok);
            n_checks++;
            if (!ok) $display("FAIL random_drain dut%0d: pending %0d, required 0", g, sb[g].size());
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < ND; g++) begin
            in_valid[g]  = 1'b0;
            in_data[g]   = '0;
            in_shamt[g]  = '0;
            in_op[g]     = '0;
            out_ready[g] = 1'b1;
            exact_lat[g] = 1'b1;
        end
        test_reset();
        test_rotate();
        test_shifts();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_shamt_zero();
        test_random();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
